// File: rtl/conv_encoder_tx_if.sv
// conv_encoder_tx_if: bit-in / symbol-out handshake bundle for conv_encoder_tx.
interface conv_encoder_tx_if;
   logic       enable_i;
   logic       d_in;
   logic       last_i;
   logic       ready_o;
   logic       valid_o;
   logic [1:0] d_out;
   logic       frame_done_o;
   logic       overflow_o;
   modport master (output enable_i, d_in, last_i, input ready_o, valid_o, d_out, frame_done_o, overflow_o);
   modport slave (input enable_i, d_in, last_i, output ready_o, valid_o, d_out, frame_done_o, overflow_o);
endinterface

// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: rate-1/2 K=3 convolutional encoder, one-cycle latency.
// CONV_ENC_TAIL_FLUSH_EN adds a two-symbol zero tail that flushes sr at frame end.
module conv_encoder_tx #(
   parameter logic [2:0] G0 = 3'b111,
   parameter logic [2:0] G1 = 3'b101
) (
   input logic clk,
   input logic rst,
   conv_encoder_tx_if.slave bus
);
`ifdef CONV_ENC_TAIL_FLUSH_EN
   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif
   state_t state, state_nxt;
   logic [1:0] sr, sr_nxt, sym, dout;
   logic d, in_tail, ready, accept, emit, last_sym, valid, done;
`ifdef CONV_ENC_TAIL_FLUSH_EN
   logic tcnt, ovf;
   assign in_tail = state == TAIL;
   assign ready = !in_tail;
   assign last_sym = in_tail && tcnt;
   assign state_nxt = in_tail ? (tcnt ? IDLE : TAIL) : accept ? (bus.last_i ? TAIL : DATA) : state;
   assign bus.overflow_o = ovf;
`else
   assign in_tail = 1'b0;
   assign ready = 1'b1;
   assign last_sym = accept && bus.last_i;
   assign state_nxt = accept ? (bus.last_i ? IDLE : DATA) : state;
   assign bus.overflow_o = 1'b0;
`endif
   assign accept = bus.enable_i && ready;
   // tail cycles shift zeros in regardless of d_in
   assign d = !in_tail && bus.d_in;
   assign emit = accept || in_tail;
   assign sym = {^(G0 & {d, sr}), ^(G1 & {d, sr})};
   assign sr_nxt = last_sym ? 2'b00 : emit ? {d, sr[1]} : sr;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sr <= 2'b00;
         valid <= 1'b0;
         dout <= 2'b00;
         done <= 1'b0;
`ifdef CONV_ENC_TAIL_FLUSH_EN
         tcnt <= 1'b0;
         ovf <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         sr <= sr_nxt;
         valid <= emit;
         dout <= emit ? sym : dout;
         done <= last_sym;
`ifdef CONV_ENC_TAIL_FLUSH_EN
         tcnt <= in_tail && !tcnt;
         ovf <= ovf || (bus.enable_i && !ready);
`endif
      end
   end
   assign bus.ready_o = ready;
   assign bus.valid_o = valid;
   assign bus.d_out = dout;
   assign bus.frame_done_o = done;
endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx: directed scoreboard bench; expectations follow the build's
// CONV_ENC_TAIL_FLUSH_EN setting.
module tb_conv_encoder_tx;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int tests = 0;
   int errs = 0;
   logic [2:0] q[$];
   logic [2:0] exp_sym;
   conv_encoder_tx_if bus ();
   conv_encoder_tx dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // symbol = {d_out, frame_done}
   always @(negedge clk) begin
      if (rst) begin
         if (bus.valid_o) begin
            if (q.size() == 0) chk("unexpected_symbol", {1'b1, bus.d_out, bus.frame_done_o}, 4'h0);
            else begin
               exp_sym = q.pop_front();
               chk("symbol", {1'b0, bus.d_out, bus.frame_done_o}, {1'b0, exp_sym});
            end
         end else if (bus.frame_done_o) chk("stray_frame_done", 4'h1, 4'h0);
      end
   end

   task automatic put(input logic d, input logic last, input logic [1:0] s, input logic fd);
      bus.enable_i = 1'b1;
      bus.d_in = d;
      bus.last_i = last;
      q.push_back({s, fd});
      @(posedge clk);
      #1;
      bus.enable_i = 1'b0;
      bus.last_i = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_vals(input string nm);
      chk({nm, "_ready"}, {3'b0, bus.ready_o}, 4'h1);
      chk({nm, "_valid"}, {3'b0, bus.valid_o}, 4'h0);
      chk({nm, "_d_out"}, {2'b0, bus.d_out}, 4'h0);
      chk({nm, "_frame_done"}, {3'b0, bus.frame_done_o}, 4'h0);
      chk({nm, "_overflow"}, {3'b0, bus.overflow_o}, 4'h0);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) idle();
      chk("drain_pending", q.size() > 0 ? 4'h1 : 4'h0, 4'h0);
   endtask

   initial begin
      bus.enable_i = 1'b1;
      bus.d_in = 1'b1;
      bus.last_i = 1'b1;
      repeat (3) idle();
      reset_vals("reset");
      bus.enable_i = 1'b0;
      bus.last_i = 1'b0;
      rst = 1'b1;
      idle();
`ifdef CONV_ENC_TAIL_FLUSH_EN
      // frame 1,0,1,1 then two tail symbols
      put(1, 0, 2'b11, 0);
      put(0, 0, 2'b10, 0);
      put(1, 0, 2'b00, 0);
      put(1, 1, 2'b01, 0);
      q.push_back({2'b01, 1'b0});
      q.push_back({2'b11, 1'b1});
      chk("tail_ready_0", {3'b0, bus.ready_o}, 4'h0);
      idle();
      chk("tail_ready_1", {3'b0, bus.ready_o}, 4'h0);
      idle();
      chk("post_tail_ready", {3'b0, bus.ready_o}, 4'h1);
      drain();
      // gap inside frame: 1, gap, 0(last) then tail 11, 00
      put(1, 0, 2'b11, 0);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("gap_valid", {3'b0, bus.valid_o}, 4'h0);
      end
      put(0, 1, 2'b10, 0);
      q.push_back({2'b11, 1'b0});
      q.push_back({2'b00, 1'b1});
      drain();
      // single-bit frame with enable in first tail cycle
      put(1, 1, 2'b11, 0);
      q.push_back({2'b10, 1'b0});
      q.push_back({2'b11, 1'b1});
      bus.enable_i = 1'b1;
      bus.d_in = 1'b1;
      idle();
      bus.enable_i = 1'b0;
      chk("overflow_set", {3'b0, bus.overflow_o}, 4'h1);
      drain();
      repeat (3) idle();
      chk("overflow_sticky", {3'b0, bus.overflow_o}, 4'h1);
      // reset after the first tail symbol
      put(1, 0, 2'b11, 0);
      put(0, 0, 2'b10, 0);
      put(1, 0, 2'b00, 0);
      put(1, 1, 2'b01, 0);
      q.push_back({2'b01, 1'b0});
      q.push_back({2'b11, 1'b1});
      idle();
      @(negedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      #1;
      reset_vals("midtail_reset");
      idle();
      rst = 1'b1;
      put(1, 1, 2'b11, 0);
      q.push_back({2'b10, 1'b0});
      q.push_back({2'b11, 1'b1});
      drain();
`else
      // frame 1,0,1,1 with frame_done on the last symbol, then next frame bit 1
      put(1, 0, 2'b11, 0);
      put(0, 0, 2'b10, 0);
      put(1, 0, 2'b00, 0);
      put(1, 1, 2'b01, 1);
      chk("ready_after_last", {3'b0, bus.ready_o}, 4'h1);
      put(1, 1, 2'b11, 1);
      drain();
      // gap inside frame
      put(1, 0, 2'b11, 0);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("gap_valid", {3'b0, bus.valid_o}, 4'h0);
      end
      put(0, 1, 2'b10, 1);
      drain();
      chk("overflow_tied", {3'b0, bus.overflow_o}, 4'h0);
      // reset mid-frame, then a fresh frame
      put(1, 0, 2'b11, 0);
      put(0, 0, 2'b10, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      #1;
      reset_vals("midframe_reset");
      idle();
      rst = 1'b1;
      put(1, 0, 2'b11, 0);
      put(1, 1, 2'b01, 1);
      drain();
`endif
      repeat (3) idle();
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule
